// File: rtl/reg_writeback_pkg.sv
// Shared processor types for the write-back path: datapath widths, the
// pending-write queue entry and the forwarding lookup result.
package reg_writeback_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_result_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Write-back bus: result offer handshake, register-file write port and the
// two operand forwarding lookups.
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  logic              wr_grant;
  logic              load;
  logic [ADDR_W-1:0] C_addr;
  logic [DATA_W-1:0] C;

  logic [ADDR_W-1:0] fwd_addr_a;
  logic [ADDR_W-1:0] fwd_addr_b;
  logic              fwd_hit_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;

  modport master (
    output in_valid, in_addr, in_data, wr_grant, fwd_addr_a, fwd_addr_b,
    input  in_ready, load, C_addr, C, fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
  );

  modport slave (
    input  in_valid, in_addr, in_data, wr_grant, fwd_addr_a, fwd_addr_b,
    output in_ready, load, C_addr, C, fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
  );

endinterface

// File: rtl/wb_queue.sv
// In-order circular queue of pending register writes. The caller decides
// when to push and pop; all entries are exposed for forwarding lookups.
module wb_queue
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  wb_entry_t        push_entry_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output wb_entry_t        entries_o [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every next-state value gets a default first, so no path through this block can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry array has no reset; count alone decides which slots hold live data.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

endmodule

// File: rtl/reg_writeback.sv
// Write-back buffer: queues results, drains one per granted cycle into the
// register-file write stage, and forwards pending values to operand lookups.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           clear_n,
  reg_writeback_if.slave wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  logic              load_q, load_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [DATA_W-1:0] c_q, c_d;

  fwd_result_t fwd_a;
  fwd_result_t fwd_b;

  // Readiness depends only on registered occupancy, so a full queue stays closed even while draining.
  assign wb.in_ready = (count < DEPTH_C);
  assign push        = wb.in_valid && wb.in_ready;
  assign pop         = (count != '0) && wb.wr_grant;

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock        (clock),
    .clear_n      (clear_n),
    .push_i       (push),
    .pop_i        (pop),
    .push_entry_i ('{addr: wb.in_addr, data: wb.in_data}),
    .head_o       (head),
    .count_o      (count),
    .rd_ptr_o     (rd_ptr),
    .entries_o    (entries)
  );

  always_comb begin
    load_d   = 1'b0;
    c_addr_d = c_addr_q;
    c_d      = c_q;
    if (pop) begin
      load_d   = 1'b1;
      c_addr_d = head.addr;
      c_d      = head.data;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      load_q   <= 1'b0;
      c_addr_q <= '0;
      c_q      <= '0;
    end else begin
      load_q   <= load_d;
      c_addr_q <= c_addr_d;
      c_q      <= c_d;
    end
  end

  assign wb.load   = load_q;
  assign wb.C_addr = c_addr_q;
  assign wb.C      = c_q;

  // Lowest priority is checked first and overwritten: output stage, then queue oldest-to-newest.
  function automatic fwd_result_t fwd_lookup(
    input logic [ADDR_W-1:0] addr,
    input wb_entry_t         ent [DEPTH],
    input logic [PTR_W-1:0]  rd_ptr_v,
    input logic [CNT_W-1:0]  count_v,
    input logic              out_valid,
    input logic [ADDR_W-1:0] out_addr,
    input logic [DATA_W-1:0] out_data
  );
    fwd_result_t      res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (out_valid && (out_addr == addr)) begin
      res.hit  = 1'b1;
      res.data = out_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_v + PTR_W'(k);
      if ((CNT_W'(k) < count_v) && (ent[idx].addr == addr)) begin
        res.hit  = 1'b1;
        res.data = ent[idx].data;
      end
    end
    return res;
  endfunction

  always_comb begin
    fwd_a = fwd_lookup(wb.fwd_addr_a, entries, rd_ptr, count, load_q, c_addr_q, c_q);
    fwd_b = fwd_lookup(wb.fwd_addr_b, entries, rd_ptr, count, load_q, c_addr_q, c_q);
  end

  assign wb.fwd_hit_a  = fwd_a.hit;
  assign wb.fwd_data_a = fwd_a.data;
  assign wb.fwd_hit_b  = fwd_b.hit;
  assign wb.fwd_data_b = fwd_b.data;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback with DEPTH=4.
module tb_reg_writeback;

  logic clock;
  logic clear_n;

  reg_writeback_if bus ();

  reg_writeback #(
    .DEPTH (4)
  ) u_dut (
    .clock   (clock),
    .clear_n (clear_n),
    .wb      (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [3:0] addr, input logic [15:0] data);
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic [15:0] exp_d [8];
  logic [3:0]  exp_a [8];

  initial begin
    clear_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.wr_grant   = 1'b0;
    bus.fwd_addr_a = '0;
    bus.fwd_addr_b = '0;
    tick();
    tick();
    clear_n = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_load", bus.load, 0);
    check("rst_c", bus.C, 0);
    check("rst_c_addr", bus.C_addr, 0);
    check("rst_hit_a", bus.fwd_hit_a, 0);
    check("rst_hit_b", bus.fwd_hit_b, 0);
    check("rst_data_a", bus.fwd_data_a, 0);

    // Single write: accept at edge N, load after edge N+1.
    bus.wr_grant = 1'b1;
    offer(4'd3, 16'h1234);
    check("lat_load_early", bus.load, 0);
    bus.fwd_addr_a = 4'd3;
    #1;
    check("lat_fwd_q_hit", bus.fwd_hit_a, 1);
    check("lat_fwd_q_data", bus.fwd_data_a, 16'h1234);
    tick();
    check("lat_load", bus.load, 1);
    check("lat_c_addr", bus.C_addr, 3);
    check("lat_c", bus.C, 16'h1234);
    check("lat_fwd_out_hit", bus.fwd_hit_a, 1);
    check("lat_fwd_out_data", bus.fwd_data_a, 16'h1234);
    tick();
    check("lat_load_after", bus.load, 0);
    check("lat_c_hold", bus.C, 16'h1234);
    check("lat_c_addr_hold", bus.C_addr, 3);
    check("lat_fwd_gone", bus.fwd_hit_a, 0);

    // Fill to capacity, refused fifth offer, then drain in order.
    bus.wr_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("fill_ready", bus.in_ready, 1);
      offer(4'(i), 16'h1000 + 16'(i));
    end
    check("full_not_ready", bus.in_ready, 0);
    check("full_count", 16'(u_dut.u_queue.count_q), 4);
    offer(4'd9, 16'hdead);
    check("full_count_kept", 16'(u_dut.u_queue.count_q), 4);
    check("full_no_load", bus.load, 0);
    bus.in_valid = 1'b1;
    bus.wr_grant = 1'b1;
    #1;
    check("full_ready_with_grant", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    check("drain1_load", bus.load, 1);
    check("drain1_addr", bus.C_addr, 1);
    check("drain1_data", bus.C, 16'h1001);
    check("drain1_count", 16'(u_dut.u_queue.count_q), 3);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("drain_load", bus.load, 1);
      check("drain_addr", bus.C_addr, 16'(i));
      check("drain_data", bus.C, 16'h1000 + 16'(i));
    end
    tick();
    check("drain_done_load", bus.load, 0);
    check("drain_done_count", 16'(u_dut.u_queue.count_q), 0);

    // Forwarding priority among duplicate addresses and the output stage.
    bus.wr_grant = 1'b0;
    offer(4'd5, 16'h0001);
    offer(4'd5, 16'h0002);
    bus.fwd_addr_a = 4'd5;
    bus.fwd_addr_b = 4'd6;
    #1;
    check("fwd_dup_hit", bus.fwd_hit_a, 1);
    check("fwd_dup_newest", bus.fwd_data_a, 16'h0002);
    check("fwd_miss_hit", bus.fwd_hit_b, 0);
    check("fwd_miss_data", bus.fwd_data_b, 0);
    bus.in_valid = 1'b1;
    bus.in_addr  = 4'd6;
    bus.in_data  = 16'h0666;
    #1;
    check("fwd_offer_excluded_hit", bus.fwd_hit_b, 0);
    check("fwd_offer_excluded_data", bus.fwd_data_b, 0);
    bus.in_valid = 1'b0;
    bus.wr_grant = 1'b1;
    tick();
    check("fwd_pop1_load", bus.load, 1);
    check("fwd_pop1_c", bus.C, 16'h0001);
    check("fwd_queue_over_out", bus.fwd_data_a, 16'h0002);
    tick();
    check("fwd_pop2_c", bus.C, 16'h0002);
    check("fwd_out_stage_hit", bus.fwd_hit_a, 1);
    check("fwd_out_stage_data", bus.fwd_data_a, 16'h0002);
    tick();
    check("fwd_idle_hit", bus.fwd_hit_a, 0);
    check("fwd_idle_data", bus.fwd_data_a, 0);

    // Steady push+pop at count 2 across pointer wrap.
    bus.wr_grant = 1'b0;
    offer(4'hA, 16'h00A0);
    offer(4'hB, 16'h00B0);
    check("steady_count_start", 16'(u_dut.u_queue.count_q), 2);
    exp_a = '{4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    exp_d = '{16'h00A0, 16'h00B0, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105};
    bus.wr_grant = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_addr = 4'(i);
      bus.in_data = 16'h0100 + 16'(i);
      tick();
      check("steady_count", 16'(u_dut.u_queue.count_q), 2);
      check("steady_load", bus.load, 1);
      check("steady_addr", bus.C_addr, 16'(exp_a[i]));
      check("steady_data", bus.C, exp_d[i]);
    end
    bus.in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      tick();
      check("steady_tail_load", bus.load, 1);
      check("steady_tail_addr", bus.C_addr, 16'(exp_a[i]));
      check("steady_tail_data", bus.C, exp_d[i]);
    end
    tick();
    check("steady_end_load", bus.load, 0);

    // Reset with pending writes drops them all.
    bus.wr_grant = 1'b0;
    offer(4'd8, 16'h0808);
    offer(4'd9, 16'h0909);
    offer(4'd10, 16'h0A0A);
    bus.fwd_addr_a = 4'd8;
    bus.fwd_addr_b = 4'd10;
    #1;
    check("pre_rst_hit_a", bus.fwd_hit_a, 1);
    check("pre_rst_data_b", bus.fwd_data_b, 16'h0A0A);
    clear_n      = 1'b0;
    bus.wr_grant = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 4'd7;
    bus.in_data  = 16'h7777;
    tick();
    clear_n      = 1'b1;
    bus.in_valid = 1'b0;
    check("mid_rst_load", bus.load, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    check("mid_rst_hit_a", bus.fwd_hit_a, 0);
    check("mid_rst_hit_b", bus.fwd_hit_b, 0);
    check("mid_rst_count", 16'(u_dut.u_queue.count_q), 0);
    check("mid_rst_c", bus.C, 0);
    check("mid_rst_c_addr", bus.C_addr, 0);
    bus.fwd_addr_a = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_load", bus.load, 0);
      check("post_rst_offer_dropped", bus.fwd_hit_a, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
